// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the binary number game.
// Drives the number generator, times each guess window, checks the
// player's switch value and keeps the score over a fixed number of rounds.
module game_round_ctrl #(
    parameter int unsigned ROUNDS     = 8,
    parameter int unsigned TIME_LIMIT = 200,
    parameter int unsigned GEN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       tick,
    input  logic [0:3] gen_result,
    output logic       gen_enable,
    input  logic [0:3] guess,
    input  logic       submit,
    output logic [0:3] target,
    output logic [7:0] time_left,
    output logic [3:0] round_no,
    output logic [3:0] score,
    output logic       busy,
    output logic       hit,
    output logic       miss,
    output logic       done
);

    localparam int unsigned NUM_W = 4;
    localparam int unsigned TIME_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GEN_W = (GEN_CYCLES < 2) ? 1 : $clog2(GEN_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state, state_d;
    logic [GEN_W-1:0]   gen_cnt, gen_cnt_d;
    logic               has_prev, has_prev_d;
    logic               timeout, timeout_d;
    logic [0:NUM_W-1]   guess_q, guess_q_d;
    logic [0:NUM_W-1]   target_d;
    logic [TIME_W-1:0]  time_left_d;
    logic [CNT_W-1:0]   round_no_d;
    logic [CNT_W-1:0]   score_d;
    logic               gen_enable_d;
    logic               busy_d;
    logic               hit_d;
    logic               miss_d;
    logic               done_d;

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gen_cnt    <= '0;
            has_prev   <= 1'b0;
            timeout    <= 1'b0;
            guess_q    <= '0;
            target     <= '0;
            time_left  <= '0;
            round_no   <= '0;
            score      <= '0;
            gen_enable <= 1'b0;
            busy       <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            gen_cnt    <= gen_cnt_d;
            has_prev   <= has_prev_d;
            timeout    <= timeout_d;
            guess_q    <= guess_q_d;
            target     <= target_d;
            time_left  <= time_left_d;
            round_no   <= round_no_d;
            score      <= score_d;
            gen_enable <= gen_enable_d;
            busy       <= busy_d;
            hit        <= hit_d;
            miss       <= miss_d;
            done       <= done_d;
        end
    end

    // Next-state and next-output logic; outputs are decoded from the next
    // state so the registered copies line up with the state they describe.
    always_comb begin
        state_d     = state;
        gen_cnt_d   = gen_cnt;
        has_prev_d  = has_prev;
        timeout_d   = timeout;
        guess_q_d   = guess_q;
        target_d    = target;
        time_left_d = time_left;
        round_no_d  = round_no;
        score_d     = score;
        hit_d       = 1'b0;
        miss_d      = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    score_d    = '0;
                    round_no_d = '0;
                    has_prev_d = 1'b0;
                    timeout_d  = 1'b0;
                    gen_cnt_d  = '0;
                    state_d    = GEN;
                end
            end
            GEN: begin
                if (gen_cnt == GEN_W'(GEN_CYCLES - 1)) begin
                    gen_cnt_d = '0;
                    state_d   = LOAD;
                end else begin
                    gen_cnt_d = gen_cnt + GEN_W'(1);
                end
            end
            LOAD: begin
                // Never present the same number twice in a row: reroll.
                if (has_prev && (gen_result == target)) begin
                    state_d = GEN;
                end else begin
                    target_d    = gen_result;
                    has_prev_d  = 1'b1;
                    time_left_d = TIME_W'(TIME_LIMIT);
                    state_d     = PLAY;
                end
            end
            PLAY: begin
                // A submit beats a simultaneous tick.
                if (submit) begin
                    guess_q_d = guess;
                    timeout_d = 1'b0;
                    hit_d     = (guess == target);
                    miss_d    = (guess != target);
                    state_d   = CHECK;
                end else if (tick) begin
                    if (time_left <= TIME_W'(1)) begin
                        time_left_d = '0;
                        timeout_d   = 1'b1;
                        miss_d      = 1'b1;
                        state_d     = CHECK;
                    end else begin
                        time_left_d = time_left - TIME_W'(1);
                    end
                end
            end
            CHECK: begin
                if (!timeout && (guess_q == target) && (score != CNT_W'(15))) begin
                    score_d = score + CNT_W'(1);
                end
                round_no_d = round_no + CNT_W'(1);
                if (round_no == CNT_W'(ROUNDS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = GEN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gen_enable_d = (state_d == GEN);
        busy_d       = (state_d == GEN) || (state_d == LOAD) ||
                       (state_d == PLAY) || (state_d == CHECK);
        done_d       = (state_d == DONE);
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: one vector table walking two full
// games, plus hand-written sequences for reset and generator timing.
module tb_game_round_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       tick;
    logic [0:3] gen_result;
    logic       gen_enable;
    logic [0:3] guess;
    logic       submit;
    logic [0:3] target;
    logic [7:0] time_left;
    logic [3:0] round_no;
    logic [3:0] score;
    logic       busy;
    logic       hit;
    logic       miss;
    logic       done;

    int applied = 0;
    int errors  = 0;

    game_round_ctrl #(
        .ROUNDS    (2),
        .TIME_LIMIT(3),
        .GEN_CYCLES(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tick      (tick),
        .gen_result(gen_result),
        .gen_enable(gen_enable),
        .guess     (guess),
        .submit    (submit),
        .target    (target),
        .time_left (time_left),
        .round_no  (round_no),
        .score     (score),
        .busy      (busy),
        .hit       (hit),
        .miss      (miss),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       tk;
        logic       sb;
        logic [3:0] gs;
        logic [3:0] gr;
        logic       e_ge;
        logic       e_bz;
        logic       e_dn;
        logic       e_ht;
        logic       e_ms;
        logic [3:0] e_tgt;
        logic [7:0] e_tl;
        logic [3:0] e_rn;
        logic [3:0] e_sc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic tk, input logic sb,
                       input logic [3:0] gs, input logic [3:0] gr,
                       input logic ge, input logic bz, input logic dn,
                       input logic ht, input logic ms, input logic [3:0] tgt,
                       input logic [7:0] tl, input logic [3:0] rn,
                       input logic [3:0] sc);
        vec_t v;
        v.st = st; v.tk = tk; v.sb = sb; v.gs = gs; v.gr = gr;
        v.e_ge = ge; v.e_bz = bz; v.e_dn = dn; v.e_ht = ht; v.e_ms = ms;
        v.e_tgt = tgt; v.e_tl = tl; v.e_rn = rn; v.e_sc = sc;
        vecs.push_back(v);
    endtask

    function automatic logic [26:0] actual_outs();
        return {gen_enable, busy, done, hit, miss, target, time_left, round_no, score};
    endfunction

    // Compares all outputs against one packed expectation.
    task automatic check(input string name, input logic [26:0] exp);
        logic [26:0] act;
        act = actual_outs();
        applied++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ge=%b busy=%b done=%b hit=%b miss=%b tgt=%h tl=%0d rn=%0d sc=%0d, want ge=%b busy=%b done=%b hit=%b miss=%b tgt=%h tl=%0d rn=%0d sc=%0d",
                     name, act[26], act[25], act[24], act[23], act[22], act[21:18],
                     act[17:10], act[9:6], act[5:0] & 6'hF,
                     exp[26], exp[25], exp[24], exp[23], exp[22], exp[21:18],
                     exp[17:10], exp[9:6], exp[5:0] & 6'hF);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        applied++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; tick = 1'b0; submit = 1'b0; guess = 4'h0;
    endtask

    initial begin
        int ge_cnt;
        int edges;
        int bound;
        string nm;

        rst_n = 1'b0;
        idle_inputs();
        gen_result = 4'hA;
        #1;
        check("reset_state", 27'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        //   st tk sb gs    gr   | ge bz dn ht ms tgt   tl rn sc
        add(1, 0, 0, 4'h0, 4'hA, 1, 1, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'hA, 1, 1, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'hA, 1, 1, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'hA, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'hA, 0, 1, 0, 0, 0, 4'hA, 3, 0, 0);
        add(0, 0, 1, 4'hA, 4'hA, 0, 1, 0, 1, 0, 4'hA, 3, 0, 0);
        add(0, 0, 0, 4'h0, 4'hA, 1, 1, 0, 0, 0, 4'hA, 3, 1, 1);
        add(0, 0, 0, 4'h0, 4'hA, 1, 1, 0, 0, 0, 4'hA, 3, 1, 1);
        add(0, 0, 0, 4'h0, 4'hA, 1, 1, 0, 0, 0, 4'hA, 3, 1, 1);
        add(0, 0, 0, 4'h0, 4'hA, 0, 1, 0, 0, 0, 4'hA, 3, 1, 1);
        add(0, 0, 0, 4'h0, 4'hA, 1, 1, 0, 0, 0, 4'hA, 3, 1, 1);
        add(0, 0, 0, 4'h0, 4'hA, 1, 1, 0, 0, 0, 4'hA, 3, 1, 1);
        add(0, 0, 0, 4'h0, 4'hA, 1, 1, 0, 0, 0, 4'hA, 3, 1, 1);
        add(0, 0, 0, 4'h0, 4'hA, 0, 1, 0, 0, 0, 4'hA, 3, 1, 1);
        add(0, 0, 0, 4'h0, 4'h5, 0, 1, 0, 0, 0, 4'h5, 3, 1, 1);
        add(0, 1, 0, 4'h0, 4'h5, 0, 1, 0, 0, 0, 4'h5, 2, 1, 1);
        add(1, 1, 0, 4'h0, 4'h5, 0, 1, 0, 0, 0, 4'h5, 1, 1, 1);
        add(0, 1, 1, 4'h5, 4'h5, 0, 1, 0, 1, 0, 4'h5, 1, 1, 1);
        add(0, 0, 0, 4'h0, 4'h5, 0, 0, 1, 0, 0, 4'h5, 1, 2, 2);
        add(0, 1, 1, 4'h0, 4'h5, 0, 0, 1, 0, 0, 4'h5, 1, 2, 2);
        add(1, 0, 0, 4'h0, 4'h5, 1, 1, 0, 0, 0, 4'h5, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h5, 1, 1, 0, 0, 0, 4'h5, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h5, 1, 1, 0, 0, 0, 4'h5, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h5, 0, 1, 0, 0, 0, 4'h5, 1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h5, 0, 1, 0, 0, 0, 4'h5, 3, 0, 0);
        add(0, 1, 0, 4'h0, 4'h5, 0, 1, 0, 0, 0, 4'h5, 2, 0, 0);
        add(0, 1, 0, 4'h0, 4'h5, 0, 1, 0, 0, 0, 4'h5, 1, 0, 0);
        add(0, 1, 0, 4'h0, 4'h5, 0, 1, 0, 0, 1, 4'h5, 0, 0, 0);
        add(0, 0, 0, 4'h0, 4'h5, 1, 1, 0, 0, 0, 4'h5, 0, 1, 0);
        add(0, 0, 0, 4'h0, 4'h5, 1, 1, 0, 0, 0, 4'h5, 0, 1, 0);
        add(0, 0, 0, 4'h0, 4'h5, 1, 1, 0, 0, 0, 4'h5, 0, 1, 0);
        add(0, 0, 0, 4'h0, 4'h5, 0, 1, 0, 0, 0, 4'h5, 0, 1, 0);
        add(0, 0, 0, 4'h0, 4'h3, 0, 1, 0, 0, 0, 4'h3, 3, 1, 0);
        add(0, 0, 1, 4'h0, 4'h3, 0, 1, 0, 0, 1, 4'h3, 3, 1, 0);
        add(0, 0, 0, 4'h0, 4'h3, 0, 0, 1, 0, 0, 4'h3, 3, 2, 0);

        foreach (vecs[i]) begin
            start      = vecs[i].st;
            tick       = vecs[i].tk;
            submit     = vecs[i].sb;
            guess      = vecs[i].gs;
            gen_result = vecs[i].gr;
            step();
            nm = $sformatf("vec%0d", i);
            check(nm, {vecs[i].e_ge, vecs[i].e_bz, vecs[i].e_dn, vecs[i].e_ht,
                       vecs[i].e_ms, vecs[i].e_tgt, vecs[i].e_tl, vecs[i].e_rn,
                       vecs[i].e_sc});
        end
        idle_inputs();

        // Asynchronous reset while in PLAY clears outputs before any edge.
        gen_result = 4'h9;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("reach_play", {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 8'd3, 4'd0, 4'd0});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_play", 27'd0);
        step();
        check("reset_held_over_edge", 27'd0);
        rst_n = 1'b1;
        step();
        check("idle_after_reset", 27'd0);

        // gen_enable width and start-to-PLAY latency from a fresh reset.
        gen_result = 4'h6;
        start = 1'b1;
        step();
        start = 1'b0;
        ge_cnt = gen_enable ? 1 : 0;
        edges = 1;
        bound = 0;
        while (!(busy && !gen_enable && time_left == 8'd3) && bound < 20) begin
            step();
            edges++;
            bound++;
            if (gen_enable) ge_cnt++;
        end
        check_int("play_reached_in_bound", (bound < 20) ? 1 : 0, 1);
        check_int("gen_enable_cycles", ge_cnt, 3);
        check_int("start_to_play_edges", edges, 5);
        check_int("target_loaded", int'(target), 6);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
